// File: rtl/kb_blink_multi.sv
// Multi-channel LED blinker: each channel is off, steady, square-wave blink or
// repeating burst. Channels keep independent phase counters.
module kb_blink_multi #(
  parameter int CHANNELS    = 4,
  parameter int HALF_PERIOD = 8388608,
  parameter int BURST_LEN   = 3,
  parameter int GAP_HALVES  = 4,
  parameter int CNT_W       = $clog2(HALF_PERIOD)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   en,
  input  logic [2*CHANNELS-1:0] mode,
  output logic [CHANNELS-1:0]   out,
  output logic [CHANNELS-1:0]   burst_done
);

  localparam int PW = $clog2(BURST_LEN + 1);
  localparam int HW = $clog2(GAP_HALVES + 1);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(HALF_PERIOD - 1);
  localparam logic [PW-1:0]    PULSE_LAST = PW'(BURST_LEN - 1);
  localparam logic [HW-1:0]    HALF_LAST  = HW'(GAP_HALVES - 1);

  typedef enum logic [2:0] {IDLE, STEADY, ON, OFF, GAP} state_t;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [PW-1:0]    pulse_idx, pulse_idx_n;
    logic [HW-1:0]    half, half_n;
    logic             out_q, out_n;
    logic             done_q, done_n;
    logic             active, active_q;
    logic [1:0]       mode_i, mode_q;
    logic             restart, phase_end;

    assign mode_i    = mode[2*g +: 2];
    assign active    = en[g] & (mode_i != 2'b00);
    assign restart   = active & (~active_q | (mode_i != mode_q));
    assign phase_end = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state     <= IDLE;
        cnt       <= '0;
        pulse_idx <= '0;
        half      <= '0;
        out_q     <= 1'b0;
        done_q    <= 1'b0;
        active_q  <= 1'b0;
        mode_q    <= 2'b00;
      end else begin
        state     <= state_n;
        cnt       <= cnt_n;
        pulse_idx <= pulse_idx_n;
        half      <= half_n;
        out_q     <= out_n;
        done_q    <= done_n;
        active_q  <= active;
        mode_q    <= mode_i;
      end
    end

    // Priority: inactive, then restart, then the per-state phase logic.
    always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      pulse_idx_n = pulse_idx;
      half_n      = half;
      out_n       = out_q;
      done_n      = 1'b0;
      if (!active) begin
        state_n     = IDLE;
        cnt_n       = '0;
        pulse_idx_n = '0;
        half_n      = '0;
        out_n       = 1'b0;
      end else if (restart) begin
        state_n     = (mode_i == 2'b01) ? STEADY : ON;
        cnt_n       = '0;
        pulse_idx_n = '0;
        half_n      = '0;
        out_n       = 1'b1;
      end else begin
        case (state)
          STEADY: out_n = 1'b1;
          ON: begin
            cnt_n = cnt + CNT_W'(1);
            if (phase_end) begin
              cnt_n = '0;
              out_n = 1'b0;
              if (mode_i == 2'b11 && pulse_idx == PULSE_LAST) begin
                state_n = GAP;
                half_n  = '0;
                done_n  = 1'b1;
              end else begin
                state_n = OFF;
                if (mode_i == 2'b11) pulse_idx_n = pulse_idx + PW'(1);
              end
            end
          end
          OFF: begin
            cnt_n = cnt + CNT_W'(1);
            if (phase_end) begin
              cnt_n   = '0;
              state_n = ON;
              out_n   = 1'b1;
            end
          end
          GAP: begin
            // The gap counts whole half-periods so cnt never needs to exceed HALF_PERIOD.
            cnt_n = cnt + CNT_W'(1);
            if (phase_end) begin
              cnt_n = '0;
              if (half == HALF_LAST) begin
                state_n     = ON;
                out_n       = 1'b1;
                pulse_idx_n = '0;
                half_n      = '0;
              end else begin
                half_n = half + HW'(1);
              end
            end
          end
          default: begin
            state_n = IDLE;
            out_n   = 1'b0;
          end
        endcase
      end
    end

    assign out[g]        = out_q;
    assign burst_done[g] = done_q;
  end

endmodule

// File: tb/tb_kb_blink_multi.sv
// Randomised bench for kb_blink_multi: a time-since-restart reference model
// feeds a scoreboard queue that a negedge monitor drains and compares.
module tb_kb_blink_multi;
  localparam int CH = 4;
  localparam int HP = 4;
  localparam int BL = 2;
  localparam int GH = 3;
  localparam int BP = (2*BL - 1 + GH) * HP;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CH-1:0]   en = '1;
  logic [2*CH-1:0] mode = 8'hAA;
  logic [CH-1:0]   out;
  logic [CH-1:0]   burst_done;

  int passes = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  int         t_since[CH];
  bit         m_act[CH];
  logic [1:0] m_mode[CH];

  kb_blink_multi #(
    .CHANNELS(CH), .HALF_PERIOD(HP), .BURST_LEN(BL), .GAP_HALVES(GH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .out(out), .burst_done(burst_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
  endtask

  // Reference model: expected outputs follow from cycles elapsed since restart.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        m_act[c] = 1'b0; m_mode[c] = 2'b00; t_since[c] = 0;
      end
      exp_q.delete();
    end else begin
      logic [CH-1:0] eo, ed;
      eo = '0; ed = '0;
      for (int c = 0; c < CH; c++) begin
        logic [1:0] m;
        bit a;
        int ph;
        m = mode[2*c +: 2];
        a = en[c] && (m != 2'b00);
        if (a && (!m_act[c] || m != m_mode[c])) t_since[c] = 0;
        else if (a) t_since[c]++;
        if (a) begin
          case (m)
            2'b01: eo[c] = 1'b1;
            2'b10: eo[c] = ((t_since[c] / HP) % 2) == 0;
            2'b11: begin
              ph = t_since[c] % BP;
              eo[c] = (ph < (2*BL - 1)*HP) && ((ph / HP) % 2 == 0);
              ed[c] = (ph == (2*BL - 1)*HP);
            end
            default: eo[c] = 1'b0;
          endcase
        end
        m_act[c]  = a;
        m_mode[c] = m;
      end
      exp_q.push_back({eo, ed});
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check("out", out, e[7:4]);
      check("burst_done", burst_done, e[3:0]);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic set_ch(input int c, input logic e, input logic [1:0] m);
    en[c] = e;
    mode[2*c +: 2] = m;
  endtask

  initial begin
    bit found;
    #1;
    check("reset_out", out, '0);
    check("reset_done", burst_done, '0);
    step(2);
    rst = 1'b0;
    step(3);
    en = '0;
    step(2);

    // Blink ch0 for several periods.
    set_ch(0, 1'b1, 2'b10);
    step(30);
    // Burst ch1 for more than two burst periods.
    set_ch(1, 1'b1, 2'b11);
    step(60);
    // Steady ch2, then disable and re-enable.
    set_ch(2, 1'b1, 2'b01);
    step(50);
    en[2] = 1'b0;
    step(1);
    en[2] = 1'b1;
    step(5);
    // Mid-ON mode change on ch0, then mode 00 with enable held.
    en[0] = 1'b0;
    step(1);
    set_ch(0, 1'b1, 2'b10);
    step(3);
    mode[1:0] = 2'b11;
    step(30);
    mode[1:0] = 2'b00;
    step(3);

    // Independence: ch0 and ch3 offset, ch1 toggling.
    en = '0;
    step(2);
    set_ch(0, 1'b1, 2'b10);
    step(3);
    set_ch(3, 1'b1, 2'b11);
    step(10);
    mode[3:2] = 2'b11;
    for (int k = 0; k < 6; k++) begin
      en[1] = ~en[1];
      step($urandom_range(1, 7));
    end
    step(20);

    // Random segments.
    for (int s = 0; s < 120; s++) begin
      int c;
      c = $urandom_range(0, CH - 1);
      set_ch(c, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 9) == 0) mode = 8'($urandom);
      step($urandom_range(1, 30));
    end

    // Async reset in the first gap cycle.
    en = '0;
    step(2);
    set_ch(1, 1'b1, 2'b11);
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      step(1);
      if (burst_done[1]) found = 1'b1;
    end
    checks++;
    if (found) passes++;
    else $display("FAIL burst_done_wait: got no pulse expected one within 60 cycles");
    rst = 1'b1;
    #1;
    check("midgap_rst_out", out, '0);
    check("midgap_rst_done", burst_done, '0);
    step(1);
    rst = 1'b0;
    step(30);

    step(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
